// File: rtl/spi_controller.sv
// spi_controller: SPI initiator, mode 0, MSB first, 8-bit bytes, two active-low chip enables.
// Latency: first SCLK rise CLK_DIV cycles after an IDLE accept; rx_valid 17*CLK_DIV (IDLE) or
//          16*CLK_DIV (WAIT) cycles after accept.
// Backpressure: tx_ready only in IDLE and WAIT; a byte is taken on tx_valid && tx_ready.
//
// Ports:
//   clk, rst_n                  system clock, synchronous active-low reset
//   tx_data/tx_cs/tx_last       byte to send, target select (IDLE only), release CE after byte
//   tx_valid/tx_ready           per-byte handshake
//   rx_data/rx_valid            captured byte and its one-cycle update pulse
//   busy                        any CE asserted or a transfer/gap in progress
//   SPI_SCLK/MOSI/MISO/CE0/CE1  serial pins (CEs active-low, SCLK idles low)
module spi_controller #(
  parameter int CLK_DIV = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_cs,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SPI_SCLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_CE0,
  output logic       SPI_CE1
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] phase;
  logic [2:0] bit_cnt;    // completed bits of the current byte
  logic [6:0] tx_shift;   // bits still to send after the one on MOSI
  logic [7:0] rx_shift;
  logic       last_q;
  logic       phase_last;

  assign phase_last = (phase == PH_LAST);
  assign tx_ready   = (state == ST_IDLE) || (state == ST_WAIT);
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= 8'd0;
      bit_cnt  <= 3'd0;
      tx_shift <= 7'd0;
      rx_shift <= 8'd0;
      last_q   <= 1'b0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      SPI_SCLK <= 1'b0;
      SPI_MOSI <= 1'b0;
      SPI_CE0  <= 1'b1;
      SPI_CE1  <= 1'b1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            tx_shift <= tx_data[6:0];
            SPI_MOSI <= tx_data[7];
            last_q   <= tx_last;
            SPI_CE0  <= tx_cs;
            SPI_CE1  <= ~tx_cs;
            phase    <= 8'd0;
            bit_cnt  <= 3'd0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (phase_last) begin
            phase    <= 8'd0;
            SPI_SCLK <= 1'b1;
            state    <= ST_HIGH;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_HIGH: begin
          if (phase_last) begin
            phase    <= 8'd0;
            SPI_SCLK <= 1'b0;
            // Sample at the very end of the high phase to give a slow peripheral maximum setup.
            rx_shift <= {rx_shift[6:0], SPI_MISO};
            // MOSI advances on the falling edge; after bit 0 it simply holds.
            if (bit_cnt != 3'd7) begin
              SPI_MOSI <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
            end
            state <= ST_LOW;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_LOW: begin
          if (phase_last) begin
            phase   <= 8'd0;
            bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 after the 8th bit
            if (bit_cnt == 3'd7) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              state    <= last_q ? ST_HOLD : ST_WAIT;
            end else begin
              SPI_SCLK <= 1'b1;
              state    <= ST_HIGH;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_WAIT: begin
          // Chip select stays as latched from IDLE; tx_cs is ignored here.
          if (tx_valid) begin
            tx_shift <= tx_data[6:0];
            SPI_MOSI <= tx_data[7];
            last_q   <= tx_last;
            phase    <= 8'd0;
            bit_cnt  <= 3'd0;
            SPI_SCLK <= 1'b1;
            state    <= ST_HIGH;
          end
        end
        ST_HOLD: begin
          if (phase_last) begin
            phase   <= 8'd0;
            SPI_CE0 <= 1'b1;
            SPI_CE1 <= 1'b1;
            state   <= ST_GAP;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        ST_GAP: begin
          if (phase_last) begin
            phase <= 8'd0;
            state <= ST_IDLE;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: one instance at CLK_DIV=2, one at CLK_DIV=24.
module tb_spi_controller;

  localparam int LIM = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_cs, tx_last, tx_valid;
  logic       sel;       // 0 drives the CLK_DIV=2 instance, 1 the CLK_DIV=24 one
  logic       loop_en;   // instance A MISO from its own MOSI, else from the peripheral model

  logic       tx_ready_a, rx_valid_a, busy_a, sclk_a, mosi_a, miso_a, ce0_a, ce1_a;
  logic [7:0] rx_data_a;
  logic       tx_ready_b, rx_valid_b, busy_b, sclk_b, mosi_b, ce0_b, ce1_b;
  logic [7:0] rx_data_b;
  logic       model_miso;

  spi_controller #(.CLK_DIV(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_cs(tx_cs), .tx_last(tx_last),
    .tx_valid(tx_valid & ~sel), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .busy(busy_a), .SPI_SCLK(sclk_a), .SPI_MOSI(mosi_a),
    .SPI_MISO(miso_a), .SPI_CE0(ce0_a), .SPI_CE1(ce1_a)
  );

  spi_controller #(.CLK_DIV(24)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_cs(tx_cs), .tx_last(tx_last),
    .tx_valid(tx_valid & sel), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .busy(busy_b), .SPI_SCLK(sclk_b), .SPI_MOSI(mosi_b),
    .SPI_MISO(mosi_b), .SPI_CE0(ce0_b), .SPI_CE1(ce1_b)
  );

  assign miso_a = loop_en ? mosi_a : model_miso;

  wire       rdy_s  = sel ? tx_ready_b : tx_ready_a;
  wire       sclk_s = sel ? sclk_b     : sclk_a;
  wire       mosi_s = sel ? mosi_b     : mosi_a;
  wire       ce0_s  = sel ? ce0_b      : ce0_a;
  wire       ce1_s  = sel ? ce1_b      : ce1_a;
  wire       rxv_s  = sel ? rx_valid_b : rx_valid_a;
  wire [7:0] rxd_s  = sel ? rx_data_b  : rx_data_a;

  // Peripheral on CE1 of instance A: echoes each received byte on the next transfer.
  // Captures MOSI on SCLK rise, shifts MISO on SCLK fall.
  logic [7:0] m_in = 8'd0, m_out = 8'd0, m_got = 8'd0;
  int         m_cnt = 0;
  logic       m_prev = 1'b0, m_reload = 1'b0;
  always @(negedge clk) begin
    if (!ce1_a) begin
      if (sclk_a && !m_prev) begin
        m_in = {m_in[6:0], mosi_a};
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt = 0;
          m_got = m_in;
          m_reload = 1'b1;
        end
      end else if (!sclk_a && m_prev) begin
        if (m_reload) begin
          m_out = m_got;
          m_reload = 1'b0;
        end else begin
          m_out = {m_out[6:0], 1'b0};
        end
      end
    end
    m_prev = sclk_a;
  end
  assign model_miso = m_out[7];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [7:0] d, input logic cs, input logic last, output int acc);
    int n;
    tx_data  = d;
    tx_cs    = cs;
    tx_last  = last;
    tx_valid = 1'b1;
    n = 0;
    while (!rdy_s && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
    acc = cyc;
  endtask

  // Window observations from accept negedge up to and including the rx_valid negedge.
  int w_rises, w_first, w_period, w_per_err, w_hi_err, w_mosi_err, w_ce0_lo, w_ce1_lo;

  task automatic wait_rx(input int d, input int acc, output int r);
    int   n, last_rise, last_chg;
    logic ps, pm;
    bit   rise_since;
    w_rises = 0; w_first = -1; w_period = 0; w_per_err = 0; w_hi_err = 0;
    w_mosi_err = 0; w_ce0_lo = 0; w_ce1_lo = 0;
    ps = 1'b0; pm = mosi_s; last_chg = acc; last_rise = -1000; rise_since = 0;
    n = 0; r = -1;
    while (n < LIM) begin
      if (sclk_s && !ps) begin
        if (cyc - last_chg < d) w_mosi_err++;
        if (w_rises > 0) begin
          w_period = cyc - last_rise;
          if (w_period != 2 * d) w_per_err++;
        end else begin
          w_first = cyc;
        end
        last_rise = cyc;
        w_rises++;
        rise_since = 1;
      end
      if (!sclk_s && ps && (cyc - last_rise != d)) w_hi_err++;
      if (mosi_s != pm) begin
        if (rise_since && (cyc - last_rise < d)) w_mosi_err++;
        last_chg = cyc;
        rise_since = 0;
      end
      if (!ce0_s) w_ce0_lo++;
      if (!ce1_s) w_ce1_lo++;
      ps = sclk_s;
      pm = mosi_s;
      if (rxv_s) begin
        r = cyc;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (r < 0) begin
      chk("rx_timeout", 32'd1, 32'd0);
      r = cyc;
    end
  endtask

  int acc, acc2, r1, r2, n, pulses;

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'd0; tx_cs = 1'b0; tx_last = 1'b0;
    sel = 1'b0; loop_en = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_sclk",   sclk_a, 0);
    chk("rst_mosi",   mosi_a, 0);
    chk("rst_ce",     {ce0_a, ce1_a, ce0_b, ce1_b}, 4'b1111);
    chk("rst_rxdata", rx_data_a, 0);
    chk("rst_rxv",    {rx_valid_a, rx_valid_b}, 0);
    chk("rst_busy",   {busy_a, busy_b}, 0);
    chk("rst_rdy",    {tx_ready_a, tx_ready_b}, 2'b11);
    rst_n = 1'b1;
    @(negedge clk);

    // Loopback 0xA5 on CE0, single byte
    send(8'hA5, 1'b0, 1'b1, acc);
    chk("lb_ce0_at_accept", ce0_a, 0);
    wait_rx(2, acc, r1);
    chk("lb_latency", r1 - acc, 34);
    chk("lb_rxdata",  rx_data_a, 8'hA5);
    chk("lb_rises",   w_rises, 8);
    chk("lb_first_rise", w_first - acc, 2);
    chk("lb_period_err", w_per_err, 0);
    chk("lb_high_err", w_hi_err, 0);
    chk("lb_ce0_low", w_ce0_lo, r1 - acc + 1);
    chk("lb_ce1_never", w_ce1_lo, 0);
    @(negedge clk);
    chk("lb_rxv_pulse", rx_valid_a, 0);
    chk("lb_ce0_hold", ce0_a, 0);
    @(negedge clk);
    chk("lb_ce0_release", {ce0_a, ce1_a}, 2'b11);
    chk("lb_gap_rdy", tx_ready_a, 0);
    chk("lb_gap_busy", busy_a, 1);
    @(negedge clk);
    chk("lb_gap_rdy2", tx_ready_a, 0);
    @(negedge clk);
    chk("lb_idle_rdy", tx_ready_a, 1);
    chk("lb_idle_busy", busy_a, 0);

    // Echo peripheral on CE1: 0x3C (keep CE) then 0x7F (release)
    loop_en = 1'b0;
    send(8'h3C, 1'b1, 1'b0, acc);
    wait_rx(2, acc, r1);
    chk("echo1_latency", r1 - acc, 34);
    chk("echo1_rxdata", rx_data_a, 8'h00);
    chk("echo1_ce1_low", w_ce1_lo, r1 - acc + 1);
    chk("echo1_ce0_never", w_ce0_lo, 0);
    send(8'h7F, 1'b1, 1'b1, acc2);
    chk("echo_wait_accept", acc2 - r1, 1);
    wait_rx(2, acc2, r2);
    chk("echo2_latency", r2 - acc2, 32);
    chk("echo2_rxdata", rx_data_a, 8'h3C);
    chk("echo2_rises", w_rises, 8);
    chk("echo2_first_rise", r2 - w_first, 32);
    chk("echo2_ce1_low", w_ce1_lo, r2 - acc2 + 1);
    chk("echo2_model_got", m_got, 8'h7F);
    repeat (2) @(negedge clk);
    chk("echo_ce1_release", ce1_a, 1);
    repeat (3) @(negedge clk);

    // Select ignored in WAIT; valid held through HOLD/GAP
    loop_en = 1'b1;
    send(8'h11, 1'b0, 1'b0, acc);
    wait_rx(2, acc, r1);
    chk("sel1_rxdata", rx_data_a, 8'h11);
    send(8'h22, 1'b1, 1'b1, acc);
    wait_rx(2, acc, r1);
    chk("sel2_rxdata", rx_data_a, 8'h22);
    chk("sel2_ce1_never", w_ce1_lo, 0);
    chk("sel2_ce0_low", w_ce0_lo, r1 - acc + 1);
    send(8'h33, 1'b0, 1'b1, acc);
    chk("gap_no_accept", acc - r1, 5);
    wait_rx(2, acc, r2);
    chk("gap_rxdata", rx_data_a, 8'h33);
    chk("gap_latency", r2 - acc, 34);
    repeat (6) @(negedge clk);

    // Reset in the middle of a HIGH phase
    send(8'hFF, 1'b0, 1'b1, acc);
    n = 0;
    while (!sclk_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_high", sclk_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ce", {ce0_a, ce1_a}, 2'b11);
    chk("mid_rst_sclk_mosi", {sclk_a, mosi_a}, 2'b00);
    chk("mid_rst_rxdata", rx_data_a, 0);
    pulses = rx_valid_a;
    repeat (4) begin
      @(negedge clk);
      pulses += rx_valid_a;
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", tx_ready_a, 1);
    chk("post_rst_busy", busy_a, 0);
    repeat (40) begin
      @(negedge clk);
      pulses += rx_valid_a;
    end
    chk("rst_no_rxv", pulses, 0);
    send(8'h5A, 1'b0, 1'b1, acc);
    wait_rx(2, acc, r1);
    chk("post_rst_rxdata", rx_data_a, 8'h5A);
    repeat (6) @(negedge clk);

    // Clocking at CLK_DIV=24 on CE1
    sel = 1'b1;
    send(8'hC3, 1'b1, 1'b1, acc);
    wait_rx(24, acc, r1);
    chk("clk24_latency", r1 - acc, 408);
    chk("clk24_rxdata", rxd_s, 8'hC3);
    chk("clk24_rises", w_rises, 8);
    chk("clk24_first_rise", w_first - acc, 24);
    chk("clk24_period", w_period, 48);
    chk("clk24_period_err", w_per_err, 0);
    chk("clk24_high_err", w_hi_err, 0);
    chk("clk24_mosi_stable", w_mosi_err, 0);
    chk("clk24_ce0_never", w_ce0_lo, 0);
    repeat (24) @(negedge clk);
    chk("clk24_ce1_release", ce1_b, 1);
    repeat (24) @(negedge clk);
    chk("clk24_idle_rdy", tx_ready_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
